matrix_cfg_queue: RTL and testbench

- APB slave register block for the matrix multiplier; successor to the single-job register file.
- Data width, job queue depth and array height are parametrised.
- Software stages a job descriptor (A/B/C addresses, M/N/P), validates it, and pushes it into a job FIFO.
- The FIFO feeds the multiplier engine through a valid/ready handshake; engine completions are counted and reported via status.

---
 rtl/matrix_cfg_queue_pkg.sv | 48 ++++
 rtl/matrix_cfg_queue_if.sv | 23 ++
 rtl/matrix_cfg_queue_fifo.sv | 47 ++++
 rtl/matrix_cfg_queue.sv | 238 +++++++++++++++++++++++
 tb/tb_matrix_cfg_queue.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_cfg_queue_pkg.sv
// Shared definitions for the matrix multiplier job queue: register map,
// STATUS/CTRL bit positions, the job descriptor type and the dimension check.
package matrix_cfg_pkg;

    localparam int JOB_FIELD_W = 16;

    localparam logic [3:0] ADDR_A        = 4'h0;
    localparam logic [3:0] ADDR_B        = 4'h1;
    localparam logic [3:0] ADDR_C        = 4'h2;
    localparam logic [3:0] ADDR_M        = 4'h3;
    localparam logic [3:0] ADDR_N        = 4'h4;
    localparam logic [3:0] ADDR_P        = 4'h5;
    localparam logic [3:0] ADDR_CTRL     = 4'h6;
    localparam logic [3:0] ADDR_STATUS   = 4'h7;
    localparam logic [3:0] ADDR_DONE_CNT = 4'h8;
    localparam logic [3:0] ADDR_IRQ_EN   = 4'h9;
    localparam logic [3:0] ADDR_IRQ_PEND = 4'hA;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_ERR_INV   = 3;
    localparam int ST_ERR_OVF   = 4;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_PUSH    = 0;
    localparam int CTRL_CLR_ERR = 1;
    localparam int CTRL_CLR_CNT = 2;

    // Default-width job descriptor; field a lands in the MSBs.
    typedef struct packed {
        logic [JOB_FIELD_W-1:0] a;
        logic [JOB_FIELD_W-1:0] b;
        logic [JOB_FIELD_W-1:0] c;
        logic [JOB_FIELD_W-1:0] m;
        logic [JOB_FIELD_W-1:0] n;
        logic [JOB_FIELD_W-1:0] p;
    } job_t;

    // A dimension is usable by the array when non-zero, a whole number of
    // array heights, and no larger than the maximum.
    function automatic logic dim_legal(input logic [31:0] dim,
                                       input logic [31:0] height,
                                       input logic [31:0] max_dim);
        return (dim != 32'd0) && ((dim % height) == 32'd0) && (dim <= max_dim);
    endfunction

endpackage

// File: rtl/matrix_cfg_queue_if.sv
// APB bus bundle for the matrix job queue register block.
interface matrix_cfg_queue_if #(
    parameter int DATA_W = 16
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [3:0]        paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );
endinterface

// File: rtl/matrix_cfg_queue_fifo.sv
// Synchronous job descriptor FIFO. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module matrix_job_fifo
    import matrix_cfg_pkg::*;
#(
    parameter type T     = job_t,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  T        din,
    output T        dout,
    output logic    full,
    output logic    empty,
    output logic [AW:0] count
);
    T            mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == (AW+1)'(DEPTH));
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage and pointer update; overflow/underflow requests are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/matrix_cfg_queue.sv
// APB register block feeding the matrix multiplier: descriptor staging,
// validation, a job FIFO towards the engine, and completion tracking.
// Optional interrupt support is compiled in with MATRIX_CFG_QUEUE_IRQ_EN.
module matrix_cfg_queue
    import matrix_cfg_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int JOB_DEPTH    = 4,
    parameter int ARRAY_HEIGHT = 16,
    parameter int MAX_DIM      = 2048
) (
    input  logic                  pclk,
    input  logic                  preset,
    matrix_cfg_queue_if.slave     apb,
    output logic                  job_valid_o,
    input  logic                  job_ready_i,
    output logic [6*DATA_W-1:0]   job_o,
    input  logic                  done_i,
    output logic                  busy_o
`ifdef MATRIX_CFG_QUEUE_IRQ_EN
    ,
    output logic                  irq_o
`endif
);
    localparam int CW = $clog2(JOB_DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        logic [DATA_W-1:0] m;
        logic [DATA_W-1:0] n;
        logic [DATA_W-1:0] p;
    } job_w_t;

    typedef enum logic [1:0] {APB_IDLE, APB_ACC1, APB_ACC2} apb_state_t;

    apb_state_t        state, state_nxt;
    logic [DATA_W-1:0] stg_a, stg_b, stg_c, stg_m, stg_n, stg_p;
    logic [DATA_W-1:0] prdata_q, rd_val, status_val;
    logic [DATA_W-1:0] done_cnt, inflight;
    logic              err_inv, err_ovf, busy_q;
    logic              access1, commit, wr_commit, addr_bad;
    logic              push_req, dims_ok, push_inv, push_ovf, do_push;
    logic              clr_err, clr_cnt, pop, done_eff;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    job_w_t            job_in, job_head;

    assign access1   = (state == APB_ACC1) && apb.psel && apb.penable;
    assign commit    = (state == APB_ACC2) && apb.psel && apb.penable;
    assign wr_commit = commit && apb.pwrite;

`ifdef MATRIX_CFG_QUEUE_IRQ_EN
    assign addr_bad = (apb.paddr > ADDR_IRQ_PEND);
`else
    assign addr_bad = (apb.paddr > ADDR_DONE_CNT);
`endif

    assign dims_ok  = dim_legal(32'(stg_m), 32'(ARRAY_HEIGHT), 32'(MAX_DIM)) &&
                      dim_legal(32'(stg_n), 32'(ARRAY_HEIGHT), 32'(MAX_DIM)) &&
                      dim_legal(32'(stg_p), 32'(ARRAY_HEIGHT), 32'(MAX_DIM));
    assign push_req = wr_commit && (apb.paddr == ADDR_CTRL) && apb.pwdata[CTRL_PUSH];
    assign clr_err  = wr_commit && (apb.paddr == ADDR_CTRL) && apb.pwdata[CTRL_CLR_ERR];
    assign clr_cnt  = wr_commit && (apb.paddr == ADDR_CTRL) && apb.pwdata[CTRL_CLR_CNT];
    assign push_inv = push_req && !dims_ok;
    // Full is the pre-cycle state: a pop in the same cycle does not make room.
    assign push_ovf = push_req && dims_ok && fifo_full;
    assign do_push  = push_req && dims_ok && !fifo_full;

    assign apb.pready  = commit;
    assign apb.pslverr = commit && (addr_bad || push_inv || push_ovf);
    assign apb.prdata  = prdata_q;

    assign job_in      = {stg_a, stg_b, stg_c, stg_m, stg_n, stg_p};
    assign job_valid_o = !fifo_empty;
    assign job_o       = job_head;
    assign pop         = job_valid_o && job_ready_i;
    assign done_eff    = done_i && (inflight != '0);
    assign busy_o      = busy_q;

    matrix_job_fifo #(
        .T     (job_w_t),
        .DEPTH (JOB_DEPTH)
    ) u_fifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (do_push),
        .pop   (pop),
        .din   (job_in),
        .dout  (job_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // APB transfer state register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state <= APB_IDLE;
        else        state <= state_nxt;
    end

    // Setup -> first access (wait state) -> second access (commit); dropping psel aborts.
    always_comb begin
        state_nxt = state;
        case (state)
            APB_IDLE: if (apb.psel && !apb.penable) state_nxt = APB_ACC1;
            APB_ACC1: begin
                if (!apb.psel)        state_nxt = APB_IDLE;
                else if (apb.penable) state_nxt = APB_ACC2;
            end
            APB_ACC2: state_nxt = APB_IDLE;
            default:  state_nxt = APB_IDLE;
        endcase
    end

    // STATUS image assembled from live state.
    always_comb begin
        status_val = '0;
        status_val[ST_FULL]    = fifo_full;
        status_val[ST_EMPTY]   = fifo_empty;
        status_val[ST_BUSY]    = busy_q;
        status_val[ST_ERR_INV] = err_inv;
        status_val[ST_ERR_OVF] = err_ovf;
        status_val[ST_COUNT_LSB +: 4] = 4'(fifo_count);
    end

`ifdef MATRIX_CFG_QUEUE_IRQ_EN
    logic [1:0] irq_en, irq_en_nxt, irq_pend, irq_pend_nxt;
    logic       irq_q;

    // Enable write and pending W1C; new events in the same cycle win over the clear.
    always_comb begin
        irq_en_nxt   = irq_en;
        irq_pend_nxt = irq_pend;
        if (wr_commit && (apb.paddr == ADDR_IRQ_EN))   irq_en_nxt   = apb.pwdata[1:0];
        if (wr_commit && (apb.paddr == ADDR_IRQ_PEND)) irq_pend_nxt = irq_pend & ~apb.pwdata[1:0];
        if (done_i)      irq_pend_nxt[0] = 1'b1;
        if (apb.pslverr) irq_pend_nxt[1] = 1'b1;
    end

    // Interrupt registers; the output follows the updated pending/enable state.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            irq_en   <= '0;
            irq_pend <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en   <= irq_en_nxt;
            irq_pend <= irq_pend_nxt;
            irq_q    <= |(irq_pend_nxt & irq_en_nxt);
        end
    end

    assign irq_o = irq_q;
`endif

    // Read mux, sampled on the first access cycle.
    always_comb begin
        rd_val = '0;
        case (apb.paddr)
            ADDR_A:        rd_val = stg_a;
            ADDR_B:        rd_val = stg_b;
            ADDR_C:        rd_val = stg_c;
            ADDR_M:        rd_val = stg_m;
            ADDR_N:        rd_val = stg_n;
            ADDR_P:        rd_val = stg_p;
            ADDR_STATUS:   rd_val = status_val;
            ADDR_DONE_CNT: rd_val = done_cnt;
`ifdef MATRIX_CFG_QUEUE_IRQ_EN
            ADDR_IRQ_EN:   rd_val = {{(DATA_W-2){1'b0}}, irq_en};
            ADDR_IRQ_PEND: rd_val = {{(DATA_W-2){1'b0}}, irq_pend};
`endif
            default:       rd_val = '0;
        endcase
    end

    // Registered read data.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset)       prdata_q <= '0;
        else if (access1) prdata_q <= rd_val;
    end

    // Staging registers, kept after a push so a descriptor can be reused.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            stg_a <= '0; stg_b <= '0; stg_c <= '0;
            stg_m <= '0; stg_n <= '0; stg_p <= '0;
        end else if (wr_commit) begin
            case (apb.paddr)
                ADDR_A:  stg_a <= apb.pwdata;
                ADDR_B:  stg_b <= apb.pwdata;
                ADDR_C:  stg_c <= apb.pwdata;
                ADDR_M:  stg_m <= apb.pwdata;
                ADDR_N:  stg_n <= apb.pwdata;
                ADDR_P:  stg_p <= apb.pwdata;
                default: ;
            endcase
        end
    end

    // Sticky errors: the clear applies first so a same-write push can re-flag.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            err_inv <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            if (clr_err) begin
                err_inv <= 1'b0;
                err_ovf <= 1'b0;
            end
            if (push_inv) err_inv <= 1'b1;
            if (push_ovf) err_ovf <= 1'b1;
        end
    end

    // Completion counter, saturating; a clear wins over a same-cycle done.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset)                        done_cnt <= '0;
        else if (clr_cnt)                  done_cnt <= '0;
        else if (done_i && done_cnt != '1) done_cnt <= done_cnt + 1'b1;
    end

    // Jobs handed to the engine but not yet reported done, plus registered busy.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            inflight <= '0;
            busy_q   <= 1'b0;
        end else begin
            case ({pop, done_eff})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            busy_q <= (inflight != '0) || !fifo_empty;
        end
    end
endmodule

// File: tb/tb_matrix_cfg_queue.sv
// Scoreboard bench for matrix_cfg_queue: APB responses and job pops are
// checked by a monitor against queued expectations.
module tb_matrix_cfg_queue;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_cfg_queue_if #(.DATA_W(DW)) apb ();

    logic            job_valid_o, job_ready_i, done_i, busy_o;
    logic [6*DW-1:0] job_o;
`ifdef MATRIX_CFG_QUEUE_IRQ_EN
    logic            irq_o;
`endif

    matrix_cfg_queue #(
        .DATA_W(DW), .JOB_DEPTH(4), .ARRAY_HEIGHT(16), .MAX_DIM(2048)
    ) dut (
        .pclk        (clk),
        .preset      (rst),
        .apb         (apb),
        .job_valid_o (job_valid_o),
        .job_ready_i (job_ready_i),
        .job_o       (job_o),
        .done_i      (done_i),
        .busy_o      (busy_o)
`ifdef MATRIX_CFG_QUEUE_IRQ_EN
        ,
        .irq_o       (irq_o)
`endif
    );

    typedef struct packed {
        logic [3:0]    addr;
        logic [DW-1:0] data;
        logic          err;
        logic          is_rd;
    } apb_exp_t;

    apb_exp_t        apb_q[$];
    logic [6*DW-1:0] job_q[$];
    apb_exp_t        e;
    logic [6*DW-1:0] ej;
    int total = 0;
    int bad   = 0;

    function automatic logic [6*DW-1:0] mkjob(input logic [DW-1:0] a, input logic [DW-1:0] m);
        return {a, 16'h0200, 16'h0300, m, 16'h0020, 16'h0020};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: compare every APB completion and every job handoff.
    always @(negedge clk) begin
        if (!rst && apb.pready) begin
            total++;
            if (apb_q.size() == 0) begin
                bad++;
                $display("FAIL apb_unexpected addr=%0h", apb.paddr);
            end else begin
                e = apb_q.pop_front();
                if (apb.pslverr !== e.err || (e.is_rd && apb.prdata !== e.data)) begin
                    bad++;
                    $display("FAIL apb addr=%0h rd=%0b got prdata=%0h pslverr=%0b want prdata=%0h pslverr=%0b",
                             e.addr, e.is_rd, apb.prdata, apb.pslverr, e.data, e.err);
                end
            end
        end
        if (!rst && job_valid_o && job_ready_i) begin
            total++;
            if (job_q.size() == 0) begin
                bad++;
                $display("FAIL job_unexpected got=%0h", job_o);
            end else begin
                ej = job_q.pop_front();
                if (job_o !== ej) begin
                    bad++;
                    $display("FAIL job_pop got=%0h want=%0h", job_o, ej);
                end
            end
        end
    end

    task automatic xfer(input logic wr, input logic [3:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_rd, input logic exp_err, input logic rdy_commit);
        apb_q.push_back('{addr: a, data: exp_rd, err: exp_err, is_rd: !wr});
        @(posedge clk); #1 apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = a; apb.pwdata = d;
        @(posedge clk); #1 apb.penable = 1'b1;
        @(posedge clk); #1 if (rdy_commit) job_ready_i = 1'b1;
        @(posedge clk); #1 apb.psel = 1'b0; apb.penable = 1'b0; if (rdy_commit) job_ready_i = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [DW-1:0] d, input logic err);
        xfer(1'b1, a, d, '0, err, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [DW-1:0] exp, input logic err);
        xfer(1'b0, a, '0, exp, err, 1'b0);
    endtask

    task automatic pulse(input logic r, input logic d);
        @(posedge clk); #1 job_ready_i = r; done_i = d;
        @(posedge clk); #1 job_ready_i = 1'b0; done_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
        job_ready_i = 1'b0; done_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_prdata", apb.prdata, 0);
        check("rst_pready", apb.pready, 0);
        check("rst_pslverr", apb.pslverr, 0);
        check("rst_job_valid", job_valid_o, 0);
        check("rst_busy", busy_o, 0);
`ifdef MATRIX_CFG_QUEUE_IRQ_EN
        check("rst_irq", irq_o, 0);
`endif
        @(posedge clk); #1 rst = 1'b0;

        // First job, register readback and unmapped addresses
        wr(4'h0, 16'h0100, 1'b0); wr(4'h1, 16'h0200, 1'b0); wr(4'h2, 16'h0300, 1'b0);
        wr(4'h3, 16'h0020, 1'b0); wr(4'h4, 16'h0020, 1'b0); wr(4'h5, 16'h0020, 1'b0);
        rd(4'h0, 16'h0100, 1'b0);
        wr(4'h6, 16'h0001, 1'b0);
        rd(4'h7, 16'h0104, 1'b0);
        check("job_valid_t1", job_valid_o, 1);
        check("job_o_t1", job_o, mkjob(16'h0100, 16'h0020));
        rd(4'h6, 16'h0000, 1'b0);
        rd(4'hC, 16'h0000, 1'b1);
        wr(4'hF, 16'h1234, 1'b1);

        // Dimension validation, sticky clear, boundaries 0 / 2064 / 2048
        wr(4'h3, 16'h0014, 1'b0);
        wr(4'h6, 16'h0001, 1'b1);
        rd(4'h7, 16'h010C, 1'b0);
        wr(4'h6, 16'h0002, 1'b0);
        rd(4'h7, 16'h0104, 1'b0);
        wr(4'h3, 16'h0000, 1'b0); wr(4'h6, 16'h0001, 1'b1);
        wr(4'h3, 16'h0810, 1'b0); wr(4'h6, 16'h0001, 1'b1);
        wr(4'h3, 16'h0800, 1'b0); wr(4'h6, 16'h0003, 1'b0);
        rd(4'h7, 16'h0204, 1'b0);
        wr(4'h3, 16'h0020, 1'b0);

        // Fill to depth, overflow, drain in order
        wr(4'h0, 16'h0101, 1'b0); wr(4'h6, 16'h0001, 1'b0);
        wr(4'h0, 16'h0102, 1'b0); wr(4'h6, 16'h0001, 1'b0);
        wr(4'h0, 16'h0103, 1'b0); wr(4'h6, 16'h0001, 1'b1);
        rd(4'h7, 16'h0415, 1'b0);
        job_q.push_back(mkjob(16'h0100, 16'h0020));
        job_q.push_back(mkjob(16'h0100, 16'h0800));
        job_q.push_back(mkjob(16'h0101, 16'h0020));
        job_q.push_back(mkjob(16'h0102, 16'h0020));
        @(posedge clk); #1 job_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1 job_ready_i = 1'b0;
        rd(4'h7, 16'h0016, 1'b0);
        wr(4'h6, 16'h0002, 1'b0);
        repeat (4) pulse(1'b0, 1'b1);
        rd(4'h8, 16'h0004, 1'b0);
        check("busy_drained", busy_o, 0);
        wr(4'h6, 16'h0004, 1'b0);
        rd(4'h8, 16'h0000, 1'b0);

        // Push coincident with pop, then completions with one done on a pop
        wr(4'h0, 16'h0110, 1'b0); wr(4'h6, 16'h0001, 1'b0);
        job_q.push_back(mkjob(16'h0110, 16'h0020));
        wr(4'h0, 16'h0111, 1'b0);
        job_q.push_back(mkjob(16'h0111, 16'h0020));
        xfer(1'b1, 4'h6, 16'h0001, '0, 1'b0, 1'b1);
        check("busy_after_pp", busy_o, 1);
        rd(4'h7, 16'h0104, 1'b0);
        wr(4'h0, 16'h0112, 1'b0); wr(4'h6, 16'h0001, 1'b0);
        job_q.push_back(mkjob(16'h0112, 16'h0020));
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        pulse(1'b0, 1'b1);
        check("busy_one_left", busy_o, 1);
        pulse(1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1 check("busy_idle", busy_o, 0);
        rd(4'h8, 16'h0003, 1'b0);

        // Reset in the middle of a read with a job in flight and one queued
        wr(4'h0, 16'h0120, 1'b0); wr(4'h6, 16'h0001, 1'b0);
        job_q.push_back(mkjob(16'h0120, 16'h0020));
        pulse(1'b1, 1'b0);
        wr(4'h6, 16'h0001, 1'b0);
        @(posedge clk); #1 apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 4'h3;
        @(posedge clk); #1 apb.penable = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; apb.psel = 1'b0; apb.penable = 1'b0;
        @(negedge clk);
        check("mid_rst_prdata", apb.prdata, 0);
        check("mid_rst_pready", apb.pready, 0);
        check("mid_rst_pslverr", apb.pslverr, 0);
        check("mid_rst_job_valid", job_valid_o, 0);
        check("mid_rst_busy", busy_o, 0);
        rd(4'h7, 16'h0002, 1'b0);
        rd(4'h8, 16'h0000, 1'b0);
        rd(4'h3, 16'h0000, 1'b0);

`ifdef MATRIX_CFG_QUEUE_IRQ_EN
        // Done interrupt raise and W1C clear
        wr(4'h9, 16'h0001, 1'b0);
        check("irq_before_done", irq_o, 0);
        pulse(1'b0, 1'b1);
        check("irq_after_done", irq_o, 1);
        wr(4'hA, 16'h0001, 1'b0);
        check("irq_after_w1c", irq_o, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("apb_queue_empty", apb_q.size(), 0);
        check("job_queue_empty", job_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
